gen_m: RTL and testbench

- Meander (square-wave) generator paced by an external 5 ms clock-enable strobe.
- Output s is a 50 % duty square wave. Each half-period lasts x strobe ticks, so the full period is 2·x·5 ms.
- Sits downstream of the system 5 ms strobe generator. Drives slow indicators or test outputs.

---
 rtl/gen_m_pkg.sv | 7 +
 rtl/gen_m.sv | 43 ++++
 tb/tb_gen_m.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/gen_m_pkg.sv
// Shared constants for the meander generator and its benches.
package gen_m_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned T5MS_NS = 5_000_000;

endpackage

// File: rtl/gen_m.sv
// 50 % duty square-wave generator; each half-period lasts x ticks of the
// external 5 ms clock-enable strobe.
module gen_m
  import gen_m_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce5ms,
  input  logic [W-1:0] x,
  output logic         s
);

  logic [W-1:0] cnt;
  logic [W-1:0] hp;
  logic         at_end;

  // cnt never exceeds hp-1, so the counter cannot wrap even at hp = 2^W-1.
  assign at_end = (cnt == (hp - W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      s   <= 1'b0;
      hp  <= x;
    end else if (ce5ms) begin
      if (hp == '0) begin
        // Parked: keep the output low and retry the latch on every tick.
        cnt <= '0;
        s   <= 1'b0;
        hp  <= x;
      end else if (at_end) begin
        cnt <= '0;
        s   <= ~s;
        hp  <= x;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gen_m.sv
// Self-checking bench for gen_m: vector table, directed corner sequences and
// a randomized run against a countdown reference model.
module tb_gen_m;
  import gen_m_pkg::*;

  localparam int unsigned W = CNT_W;

  logic         clk;
  logic         rst;
  logic         ce5ms;
  logic [W-1:0] x;
  logic         s;

  int total = 0;
  int bad   = 0;

  gen_m #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .ce5ms (ce5ms),
    .x     (x),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         r;
    logic         c;
    logic [W-1:0] xv;
    logic         exp_s;
  } vec_t;

  vec_t tbl[26];

  // Reference model: remaining ticks in the current half-period.
  logic         m_s;
  int unsigned  m_hp;
  int unsigned  m_rem;

  task automatic model_edge(input logic r, input logic c, input logic [W-1:0] xv);
    if (r) begin
      m_s = 1'b0; m_hp = xv; m_rem = xv;
    end else if (c) begin
      if (m_hp == 0) begin
        m_s = 1'b0; m_hp = xv; m_rem = xv;
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_s = ~m_s; m_hp = xv; m_rem = xv;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [W-1:0] xv);
    @(negedge clk);
    rst = r; ce5ms = c; x = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [W-1:0] xv);
    step(1'b0, 1'b1, xv);
    step(1'b0, 1'b0, xv);
  endtask

  task automatic check(input string name, input logic act, input logic exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: s=%b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  initial begin
    logic         early;
    logic         held;
    logic [W-1:0] rx;
    logic         rr;
    logic         rc;

    rst = 1'b1; ce5ms = 1'b0; x = W'(4);

    // Table: 2 reset cycles with a live strobe, then 12 strobes of x=4,
    // each followed by an idle cycle where s must hold.
    tbl[0] = '{1'b1, 1'b1, W'(4), 1'b0};
    tbl[1] = '{1'b1, 1'b0, W'(4), 1'b0};
    for (int k = 1; k <= 12; k++) begin
      tbl[2*k]   = '{1'b0, 1'b1, W'(4), ((k / 4) % 2) == 1};
      tbl[2*k+1] = '{1'b0, 1'b0, W'(4), ((k / 4) % 2) == 1};
    end
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].xv);
      check($sformatf("tbl[%0d]", i), s, tbl[i].exp_s);
    end

    // x=1 toggles on every strobe.
    step(1'b1, 1'b0, W'(1));
    check("x1_reset", s, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      strobe(W'(1));
      check($sformatf("x1_strobe%0d", k), s, (k % 2) == 1);
    end

    // x=0 parks the output low; a later x=3 restarts on the next tick.
    step(1'b1, 1'b0, W'(0));
    held = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      strobe(W'(0));
      held = held | s;
    end
    check("x0_stays_low", held, 1'b0);
    strobe(W'(3));
    check("x0_restart_tick", s, 1'b0);
    strobe(W'(3));
    strobe(W'(3));
    check("x3_before_rise", s, 1'b0);
    strobe(W'(3));
    check("x3_rise", s, 1'b1);

    // Mid-half-period change of x takes effect at the next boundary.
    step(1'b1, 1'b0, W'(4));
    strobe(W'(4));
    strobe(W'(4));
    strobe(W'(2));
    check("mid_s3", s, 1'b0);
    strobe(W'(2));
    check("mid_s4", s, 1'b1);
    strobe(W'(2));
    check("mid_s5", s, 1'b1);
    strobe(W'(2));
    check("mid_s6", s, 1'b0);
    strobe(W'(2));
    strobe(W'(2));
    check("mid_s8", s, 1'b1);

    // Reset while high, coinciding with a strobe: reset wins.
    step(1'b1, 1'b0, W'(4));
    for (int k = 1; k <= 5; k++) strobe(W'(4));
    check("rst_mid_high_pre", s, 1'b1);
    step(1'b1, 1'b1, W'(4));
    check("rst_mid_high", s, 1'b0);
    for (int k = 1; k <= 3; k++) strobe(W'(4));
    check("rst_release_s3", s, 1'b0);
    strobe(W'(4));
    check("rst_release_s4", s, 1'b1);

    // 100 clk without strobe: s and the tick count must hold.
    step(1'b1, 1'b0, W'(4));
    for (int k = 1; k <= 5; k++) strobe(W'(4));
    early = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 1'b0, W'(4));
      early = early | ~s;
    end
    check("idle_hold", early, 1'b0);
    strobe(W'(4));
    strobe(W'(4));
    check("idle_resume_s7", s, 1'b1);
    strobe(W'(4));
    check("idle_resume_s8", s, 1'b0);

    // Maximum half-period with the strobe held high (one tick per clk).
    step(1'b1, 1'b0, W'(2047));
    early = 1'b0;
    for (int k = 1; k <= 2046; k++) begin
      step(1'b0, 1'b1, W'(2047));
      early = early | s;
    end
    check("max_no_early_toggle", early, 1'b0);
    step(1'b0, 1'b1, W'(2047));
    check("max_rise_2047", s, 1'b1);
    early = 1'b0;
    for (int k = 1; k <= 2046; k++) begin
      step(1'b0, 1'b1, W'(2047));
      early = early | ~s;
    end
    check("max_high_hold", early, 1'b0);
    step(1'b0, 1'b1, W'(2047));
    check("max_fall_4094", s, 1'b0);

    // Randomized run against the countdown model.
    step(1'b1, 1'b0, W'(3));
    model_edge(1'b1, 1'b0, W'(3));
    rx = W'(3);
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rc = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) rx = W'($urandom_range(0, 6));
      step(rr, rc, rx);
      model_edge(rr, rc, rx);
      check($sformatf("rand[%0d]", i), s, m_s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
